// File: rtl/result_wb_buffer_if.sv
// Output-memory write port of result_wb_buffer. With WB_PACK_EN defined the data
// bus widens to four elements and carries four byte-lane enables.
interface result_wb_buffer_if #(
    parameter int ADDR_SIZE  = 16,
    parameter int DATA_WIDTH = 8
);
`ifdef WB_PACK_EN
    localparam int MDW = 4 * DATA_WIDTH;
    localparam int SW  = 4;
`else
    localparam int MDW = DATA_WIDTH;
    localparam int SW  = 1;
`endif

    // Handshake: a beat transfers on a rising edge where m_valid & m_ready. Once
    // m_valid is high, m_addr/m_data/m_strb hold until that beat transfers.
    logic [ADDR_SIZE-1:0] m_addr;
    logic [MDW-1:0]       m_data;
    logic [SW-1:0]        m_strb;
    logic                 m_valid;
    logic                 m_ready;

    modport master (output m_addr, output m_data, output m_strb, output m_valid, input m_ready);
    modport slave  (input m_addr, input m_data, input m_strb, input m_valid, output m_ready);
endinterface

// File: rtl/result_wb_buffer.sv
// Write-back FIFO between the engine's result writes and the output memory port.
// Define WB_PACK_EN to merge elements into 4-lane words before they enter the FIFO.
module result_wb_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_SIZE  = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_start,
    input  logic [ADDR_SIZE-1:0]          i_result_addr,
    input  logic [DATA_WIDTH-1:0]         i_result_data,
    input  logic                          i_result_vld,
    input  logic                          i_w_done,
    result_wb_buffer_if.master            mem,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_overflow,
    output logic                          o_drain_done,
    output logic [1:0]                    o_state
);
    localparam int PW = $clog2(FIFO_DEPTH);
`ifdef WB_PACK_EN
    localparam int MDW = 4 * DATA_WIDTH;
    localparam int SW  = 4;
`else
    localparam int MDW = DATA_WIDTH;
    localparam int SW  = 1;
`endif
    localparam int EW = ADDR_SIZE + MDW + SW;
    localparam logic [PW:0] FULL_LVL = (PW+1)'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state, state_nxt;
    logic [EW-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   level;
    logic          empty, full, pop, push, drop;
    logic          push_req, stage_empty;
    logic [EW-1:0] push_entry, head;

    assign empty = (level == '0);
    assign full  = (level == FULL_LVL);

`ifdef WB_PACK_EN
    logic                 stg_vld;
    logic [ADDR_SIZE-1:0] stg_addr;
    logic [MDW-1:0]       stg_data;
    logic [3:0]           stg_strb;
    logic [1:0]           lane;
    logic [ADDR_SIZE-1:0] word;
    logic                 stg_flush;

    assign lane = i_result_addr[1:0];
    assign word = {2'b00, i_result_addr[ADDR_SIZE-1:2]};
    // A completed word (lane 3 present) leaves the stage one cycle after that write.
    assign stg_flush   = stg_vld & (stg_strb[3] | (state == S_FLUSH) |
                                    (i_result_vld & (word != stg_addr)));
    assign push_req    = stg_flush;
    assign push_entry  = {stg_addr, stg_data, stg_strb};
    assign stage_empty = !stg_vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_vld  <= 1'b0;
            stg_addr <= '0;
            stg_data <= '0;
            stg_strb <= '0;
        end else if (i_result_vld) begin
            if (stg_flush || !stg_vld) begin
                stg_vld  <= 1'b1;
                stg_addr <= word;
                stg_data <= '0;
                stg_data[lane*DATA_WIDTH +: DATA_WIDTH] <= i_result_data;
                stg_strb <= 4'b0001 << lane;
            end else begin
                stg_data[lane*DATA_WIDTH +: DATA_WIDTH] <= i_result_data;
                stg_strb[lane] <= 1'b1;
            end
        end else if (stg_flush) begin
            stg_vld <= 1'b0;
        end
    end
`else
    assign push_req    = i_result_vld;
    assign push_entry  = {i_result_addr, i_result_data, 1'b1};
    assign stage_empty = 1'b1;
`endif

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign pop  = !empty & mem.m_ready;
    assign push = push_req & (!full | pop);
    assign drop = push_req & full & !pop;

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        end
    end

    assign head         = empty ? '0 : fifo_mem[rd_ptr];
    assign {mem.m_addr, mem.m_data, mem.m_strb} = head;
    assign mem.m_valid  = !empty;
    assign o_level      = level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          o_overflow <= 1'b0;
        else if (drop)    o_overflow <= 1'b1;
        else if (i_start) o_overflow <= 1'b0;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (i_start) state_nxt = S_RUN;
            S_RUN:   if (i_start) state_nxt = S_RUN;
                     else if (i_w_done) state_nxt = S_FLUSH;
            S_FLUSH: if (i_start) state_nxt = S_RUN;
                     else if (empty && stage_empty && !i_result_vld) state_nxt = S_DONE;
            default: state_nxt = i_start ? S_RUN : S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    assign o_drain_done = (state == S_DONE);
    assign o_state      = state;
endmodule

// File: tb/tb_result_wb_buffer.sv
// Self-checking bench for result_wb_buffer: directed scenarios plus a randomized
// run checked against a queue model of the FIFO and the layer-phase rules.
module tb_result_wb_buffer;
  localparam int DW    = 8;
  localparam int AW    = 16;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start, i_result_vld, i_w_done;
  logic [AW-1:0] i_result_addr;
  logic [DW-1:0] i_result_data;
  logic [4:0]    o_level;
  logic          o_overflow, o_drain_done;
  logic [1:0]    o_state;

  int checks = 0;
  int errors = 0;

  result_wb_buffer_if #(.ADDR_SIZE(AW), .DATA_WIDTH(DW)) bus ();

  result_wb_buffer #(.DATA_WIDTH(DW), .ADDR_SIZE(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .i_start(i_start),
    .i_result_addr(i_result_addr), .i_result_data(i_result_data),
    .i_result_vld(i_result_vld), .i_w_done(i_w_done),
    .mem(bus),
    .o_level(o_level), .o_overflow(o_overflow),
    .o_drain_done(o_drain_done), .o_state(o_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    i_start = 0; i_result_vld = 0; i_w_done = 0;
    i_result_addr = '0; i_result_data = '0; bus.m_ready = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

`ifndef WB_PACK_EN
  // reference model: FIFO contents as {addr,data}, phase 0..3 = idle/run/flush/done
  logic [AW+DW-1:0] exp_q[$];
  int      model_st = 0;
  logic    model_ovf = 1'b0;
  int      beats_model = 0, beats_dut = 0, done_pulses = 0;
  logic    stall_prev = 1'b0;
  logic [AW-1:0] held_addr;
  logic [DW-1:0] held_data;

  task automatic cycle(input logic vld, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic rdy, input logic st, input logic wd);
    logic pop, acc;
    int   sz;
    @(negedge clk);
    sz = exp_q.size();
    chk("m_valid", bus.m_valid, sz != 0);
    chk("o_level", o_level, sz);
    chk("o_overflow", o_overflow, model_ovf);
    chk("o_drain_done", o_drain_done, model_st == 3);
    chk("o_state", o_state, model_st);
    if (sz != 0) begin
      chk("m_addr", bus.m_addr, exp_q[0][DW +: AW]);
      chk("m_data", bus.m_data, exp_q[0][DW-1:0]);
      chk("m_strb", bus.m_strb, 1);
    end
    if (stall_prev) begin
      chk("hold_addr", bus.m_addr, held_addr);
      chk("hold_data", bus.m_data, held_data);
    end
    if (o_drain_done) done_pulses++;
    if (bus.m_valid && rdy) beats_dut++;
    stall_prev = bus.m_valid && !rdy;
    held_addr  = bus.m_addr;
    held_data  = bus.m_data;

    i_result_vld = vld; i_result_addr = a; i_result_data = d;
    bus.m_ready = rdy; i_start = st; i_w_done = wd;

    pop = rdy && (sz != 0);
    acc = vld && (sz < DEPTH || pop);
    case (model_st)
      0: model_st = st ? 1 : 0;
      1: model_st = st ? 1 : (wd ? 2 : 1);
      2: model_st = st ? 1 : ((sz == 0 && !vld) ? 3 : 2);
      default: model_st = st ? 1 : 0;
    endcase
    if (pop) begin void'(exp_q.pop_front()); beats_model++; end
    if (acc) exp_q.push_back({a, d});
    if (vld && !acc) model_ovf = 1'b1;
    else if (st)     model_ovf = 1'b0;
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, '0, '0, rdy, 1'b0, 1'b0);
  endtask

  task automatic drain_to_idle(input int budget);
    int k = 0;
    while (k < budget && !(model_st == 0 && exp_q.size() == 0)) begin
      idle(1'b1);
      k++;
    end
    chk("drain_budget", k < budget, 1'b1);
    idle(1'b1);
  endtask
`else
  task automatic pdrive(input logic vld, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic rdy, input logic st, input logic wd);
    @(negedge clk);
    i_result_vld = vld; i_result_addr = a; i_result_data = d;
    bus.m_ready = rdy; i_start = st; i_w_done = wd;
  endtask
`endif

  initial begin
    apply_reset();
    chk("rst_valid", bus.m_valid, 1'b0);
    chk("rst_level", o_level, 0);
    chk("rst_state", o_state, 0);
`ifndef WB_PACK_EN
    // 1: reset while draining with 5 entries queued
    cycle(0, '0, '0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cycle(1, AW'(16'h40 + i), DW'(8'h30 + i), 0, 0, 0);
    idle(1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_valid", bus.m_valid, 1'b0);
    chk("rst_async_level", o_level, 0);
    chk("rst_async_done", o_drain_done, 1'b0);
    exp_q.delete(); model_st = 0; model_ovf = 0; stall_prev = 0;
    @(negedge clk);
    i_result_vld = 0; i_start = 0; i_w_done = 0; bus.m_ready = 0;
    rst = 1'b0;
    chk("rst_release_state", o_state, 0);
    idle(1'b0);

    // 2: eight writes, drained in order, one drain-done pulse
    done_pulses = 0; beats_dut = 0;
    cycle(0, '0, '0, 1, 1, 0);
    for (int i = 0; i < 8; i++) cycle(1, AW'(16'h10 + i), DW'(8'hA0 + i), 1, 0, 0);
    cycle(0, '0, '0, 1, 0, 1);
    drain_to_idle(40);
    chk("t2_beats", beats_dut, 8);
    chk("t2_done_pulses", done_pulses, 1);
    chk("t2_overflow", o_overflow, 1'b0);

    // 3: 20 writes into a stalled 16-deep FIFO
    beats_dut = 0;
    cycle(0, '0, '0, 0, 1, 0);
    for (int i = 0; i < 20; i++) cycle(1, AW'(16'h100 + i), DW'($urandom_range(0, 255)), 0, 0, 0);
    idle(1'b0);
    chk("t3_level_full", o_level, 16);
    chk("t3_overflow", o_overflow, 1'b1);
    for (int k = 0; k < 30 && exp_q.size() != 0; k++) idle(1'b1);
    idle(1'b1);
    chk("t3_beats", beats_dut, 16);

    // 4: push and pop together while full
    cycle(0, '0, '0, 0, 1, 0);
    for (int i = 0; i < 16; i++) cycle(1, AW'(16'h200 + i), DW'(i), 0, 0, 0);
    cycle(1, 16'h2FF, 8'hEE, 1, 0, 0);
    idle(1'b0);
    chk("t4_level", o_level, 16);
    chk("t4_overflow", o_overflow, 1'b0);
    for (int k = 0; k < 30 && exp_q.size() != 0; k++) idle(1'b1);

    // 5: ready toggling 1010... during six writes
    beats_dut = 0; beats_model = 0; done_pulses = 0;
    cycle(0, '0, '0, 0, 1, 0);
    for (int i = 0; i < 6; i++) cycle(1, AW'(16'h300 + i), DW'($urandom_range(0, 255)), (i % 2) == 0, 0, 0);
    for (int k = 0; k < 20; k++) idle((k % 2) == 0);
    cycle(0, '0, '0, 1, 0, 1);
    drain_to_idle(40);
    chk("t5_beats", beats_dut, 6);
    chk("t5_done_pulses", done_pulses, 1);

    // randomized traffic, then flush
    beats_dut = 0; beats_model = 0; done_pulses = 0;
    cycle(0, '0, '0, 1, 1, 0);
    for (int k = 0; k < 300; k++)
      cycle($urandom_range(0, 2) != 0, AW'($urandom), DW'($urandom), $urandom_range(0, 1) == 1, 0, 0);
    cycle(0, '0, '0, 1, 0, 1);
    drain_to_idle(60);
    chk("rand_beats", beats_dut, beats_model);
    chk("rand_done_pulses", done_pulses, 1);
`else
    // packing: three lanes of word 0x08, then a write to word 0x09
    begin
      int got9 = 0, dones = 0;
      logic [3:0] strb9 = '0;
      logic [7:0] d9 = '0;
      pdrive(0, '0, '0, 0, 1, 0);
      pdrive(1, 16'h20, 8'h11, 0, 0, 0);
      pdrive(1, 16'h21, 8'h22, 0, 0, 0);
      pdrive(1, 16'h23, 8'h44, 0, 0, 0);
      pdrive(1, 16'h24, 8'h55, 0, 0, 0);
      pdrive(0, '0, '0, 0, 0, 0);
      chk("p_valid", bus.m_valid, 1'b1);
      chk("p_addr", bus.m_addr, 16'h08);
      chk("p_strb", bus.m_strb, 4'b1011);
      chk("p_lane0", bus.m_data[7:0], 8'h11);
      chk("p_lane1", bus.m_data[15:8], 8'h22);
      chk("p_lane3", bus.m_data[31:24], 8'h44);
      pdrive(0, '0, '0, 1, 0, 1);
      for (int k = 0; k < 20; k++) begin
        pdrive(0, '0, '0, 1, 0, 0);
        if (bus.m_valid && bus.m_addr == 16'h09) begin got9++; strb9 = bus.m_strb; d9 = bus.m_data[7:0]; end
        if (o_drain_done) dones++;
      end
      chk("p_beat9_count", got9, 1);
      chk("p_beat9_strb", strb9, 4'b0001);
      chk("p_beat9_data", d9, 8'h55);
      chk("p_done_pulses", dones, 1);
    end
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
